mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's data/instruction port. It accepts one read or write request at a time over a valid/ready handshake, waits a programmable number of wait states, and then returns a registered response (read data or write acknowledge) that is held until the requester consumes it. It replaces the fixed-latency memory with a handshaked slave so the control unit can stall on memory, and it supports the byte, half and word sizes the size handler uses.

---
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Handshaked memory responder: one request at a time, programmable wait states, held response.
// Define MEM_RESP_ERR_EN to flag out-of-range, misaligned and reserved-size accesses as errors.
module mem_responder #(
    parameter int DEPTH_BYTES = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    stateT       state;
    logic [3:0]  waitCnt;
    logic        wrQ;
    logic [1:0]  sizeQ;
    logic [31:0] addrQ;
    logic [31:0] wdataQ;

    logic [7:0]    mem [DEPTH_BYTES];
    logic [AW-1:0] idx;
    logic [3:0]    laneEn;
    logic [31:0]   rdataNext;
    logic          accErr;
    logic          commit;

    // Decode the latched request into a base index, active byte lanes and read data.
    always_comb begin
        idx       = addrQ[AW-1:0];
        accErr    = 1'b0;
        laneEn    = 4'b0000;
        rdataNext = 32'd0;
`ifdef MEM_RESP_ERR_EN
        accErr = (addrQ >= 32'(DEPTH_BYTES)) || (sizeQ == 2'b11) ||
                 ((sizeQ == 2'b01) && addrQ[0]) ||
                 ((sizeQ == 2'b10) && (addrQ[1:0] != 2'b00));
`else
        case (sizeQ)
            2'b00:   idx = addrQ[AW-1:0];
            2'b01:   idx[0] = 1'b0;
            default: idx[1:0] = 2'b00;
        endcase
`endif
        case (sizeQ)
            2'b00:   laneEn = 4'b0001;
            2'b01:   laneEn = 4'b0011;
            default: laneEn = 4'b1111;
        endcase
        if (accErr) begin
            laneEn = 4'b0000;
        end
        for (int k = 0; k < 4; k++) begin
            if (laneEn[k]) begin
                rdataNext[8*k +: 8] = mem[idx + k[AW-1:0]];
            end
        end
    end

`ifndef MEM_RESP_ERR_EN
    logic unusedAddrBits;
    assign unusedAddrBits = ^addrQ[31:AW];
`endif

    assign commit = (state == WAIT) && (waitCnt == 4'd0);

    // Storage is deliberately not reset; only the enabled lanes of a committing write change.
    always_ff @(posedge clock) begin
        if (commit && wrQ) begin
            for (int k = 0; k < 4; k++) begin
                if (laneEn[k]) begin
                    mem[idx + k[AW-1:0]] <= wdataQ[8*k +: 8];
                end
            end
        end
    end

    // The WAIT count includes one access cycle, so the response lands WAIT_CYCLES+1 edges after accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            waitCnt   <= 4'd0;
            wrQ       <= 1'b0;
            sizeQ     <= 2'b00;
            addrQ     <= 32'd0;
            wdataQ    <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wrQ     <= req_wr;
                        sizeQ   <= req_size;
                        addrQ   <= req_addr;
                        wdataQ  <= req_wdata;
                        waitCnt <= 4'(WAIT_CYCLES);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (waitCnt == 4'd0) begin
                        rsp_err   <= accErr;
                        rsp_rdata <= wrQ ? 32'd0 : rdataNext;
                        state     <= RESP;
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a byte-array reference model.
// A second instance with zero wait states checks back-to-back throughput.
module tb_mem_responder;

    localparam int WC    = 2;
    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        rstN;
    logic        reqValid, reqReady, reqWr, rspValid, rspReady, rspErr, busy;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqWdata, rspRdata;

    logic        zReqValid, zReqReady, zReqWr, zRspValid, zRspReady, zRspErr, zBusy;
    logic [1:0]  zReqSize;
    logic [31:0] zReqAddr, zReqWdata, zRspRdata;

    int total = 0;
    int bad   = 0;

    logic [7:0] refMem [DEPTH];

    always #5 clock = ~clock;

    mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clock(clock), .reset(rstN),
        .req_valid(reqValid), .req_ready(reqReady), .req_wr(reqWr), .req_size(reqSize),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_rdata(rspRdata), .rsp_err(rspErr),
        .busy(busy)
    );

    mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) dutZero (
        .clock(clock), .reset(rstN),
        .req_valid(zReqValid), .req_ready(zReqReady), .req_wr(zReqWr), .req_size(zReqSize),
        .req_addr(zReqAddr), .req_wdata(zReqWdata),
        .rsp_valid(zRspValid), .rsp_ready(zRspReady), .rsp_rdata(zRspRdata), .rsp_err(zRspErr),
        .busy(zBusy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: little-endian byte array, sizes as byte counts, errors per the configured mode.
    task automatic refAccess(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] data, output logic err);
        int n;
        int base;
        n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        data = 32'd0;
`ifdef MEM_RESP_ERR_EN
        err  = (addr >= 32'(DEPTH)) || (size == 2'd3) || ((addr % 32'(n)) != 0);
        base = int'(addr % 32'(DEPTH));
`else
        err  = 1'b0;
        base = (int'(addr % 32'(DEPTH)) / n) * n;
`endif
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                if (wr) refMem[base + i] = wdata[8*i +: 8];
                else    data = data | (32'(refMem[base + i]) << (8 * i));
            end
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold, input bit pulse,
                                 output logic [31:0] gotData, output logic gotErr);
        logic [31:0] expData;
        logic        expErr;
        int          lat;
        checkOutput("ready_idle", 32'(reqReady), 32'd1);
        reqValid = 1'b1; reqWr = wr; reqSize = size; reqAddr = addr; reqWdata = wdata;
        @(posedge clock); #1;
        reqValid = 1'b0;
        refAccess(wr, size, addr, wdata, expData, expErr);
        lat = 0;
        while (!rspValid && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(WC + 1));
        gotData = rspRdata;
        gotErr  = rspErr;
        checkOutput("rdata", rspRdata, expData);
        checkOutput("err", 32'(rspErr), 32'(expErr));
        checkOutput("busy_resp", 32'(busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            if (pulse) begin
                reqValid = 1'b1; reqWr = 1'b1; reqSize = 2'd2;
                reqAddr = 32'($urandom_range(0, 63)) * 4; reqWdata = $urandom;
            end
            @(posedge clock); #1;
            checkOutput("hold_valid", 32'(rspValid), 32'd1);
            checkOutput("hold_rdata", rspRdata, expData);
            checkOutput("hold_ready", 32'(reqReady), 32'd0);
        end
        reqValid = 1'b0;
        rspReady = 1'b1;
        @(posedge clock); #1;
        rspReady = 1'b0;
        checkOutput("rsp_done", 32'(rspValid), 32'd0);
        checkOutput("ready_back", 32'(reqReady), 32'd1);
    endtask

    initial begin
        logic [31:0] d, w0;
        logic        e;
        rstN = 1'b0;
        reqValid = 0; reqWr = 0; reqSize = 0; reqAddr = 0; reqWdata = 0; rspReady = 0;
        zReqValid = 0; zReqWr = 0; zReqSize = 0; zReqAddr = 0; zReqWdata = 0; zRspReady = 0;
        #12;
        checkOutput("rst_ready", 32'(reqReady), 32'd1);
        checkOutput("rst_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rdata", rspRdata, 32'd0);
        @(posedge clock); #1;
        rstN = 1'b1;
        @(posedge clock); #1;

        for (int a = 0; a < DEPTH; a += 4) begin
            applyStimulus(1'b1, 2'd2, 32'(a), $urandom, 0, 1'b0, d, e);
        end

        applyStimulus(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0, d, e);
        applyStimulus(1'b0, 2'd2, 32'h10, 32'h0, 0, 1'b0, d, e);
        checkOutput("dir_word", d, 32'hDEADBEEF);
        applyStimulus(1'b1, 2'd0, 32'h11, 32'h0000005A, 0, 1'b0, d, e);
        applyStimulus(1'b0, 2'd2, 32'h10, 32'h0, 0, 1'b0, d, e);
        checkOutput("dir_merge", d, 32'hDEAD5AEF);
        applyStimulus(1'b0, 2'd0, 32'h13, 32'h0, 0, 1'b0, d, e);
        checkOutput("dir_byte", d, 32'h000000DE);
        applyStimulus(1'b0, 2'd1, 32'h12, 32'h0, 0, 1'b0, d, e);
        checkOutput("dir_half", d, 32'h0000DEAD);
        applyStimulus(1'b0, 2'd2, 32'h10, 32'h0, 5, 1'b1, d, e);
        applyStimulus(1'b0, 2'd2, 32'h10, 32'h0, 0, 1'b0, d, e);
        checkOutput("stall_nochange", d, 32'hDEAD5AEF);

        // Reset while a write sits in WAIT must discard it.
        reqValid = 1'b1; reqWr = 1'b1; reqSize = 2'd2; reqAddr = 32'h20; reqWdata = 32'h12345678;
        @(posedge clock); #1;
        reqValid = 1'b0;
        @(posedge clock); #1;
        checkOutput("wait_busy", 32'(busy), 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(rspValid), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_ready", 32'(reqReady), 32'd1);
        checkOutput("arst_rdata", rspRdata, 32'd0);
        checkOutput("arst_err", 32'(rspErr), 32'd0);
        @(posedge clock); #1;
        rstN = 1'b1;
        @(posedge clock); #1;
        applyStimulus(1'b0, 2'd2, 32'h20, 32'h0, 0, 1'b0, d, e);

`ifdef MEM_RESP_ERR_EN
        applyStimulus(1'b0, 2'd2, 32'h22, 32'h0, 0, 1'b0, d, e);
        checkOutput("err_misalign", 32'(e), 32'd1);
        applyStimulus(1'b0, 2'd2, 32'h100, 32'h0, 0, 1'b0, d, e);
        checkOutput("err_range", 32'(e), 32'd1);
        checkOutput("err_rdata", d, 32'd0);
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0, 0, 1'b0, w0, e);
        applyStimulus(1'b1, 2'd2, 32'h100, ~w0, 0, 1'b0, d, e);
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0, 0, 1'b0, d, e);
        checkOutput("err_nowrite", d, w0);
`else
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0, 0, 1'b0, w0, e);
        applyStimulus(1'b0, 2'd2, 32'h102, 32'h0, 0, 1'b0, d, e);
        checkOutput("wrap_word", d, w0);
        checkOutput("wrap_err", 32'(e), 32'd0);
`endif

        for (int t = 0; t < 150; t++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 511)) : 32'($urandom_range(0, 255));
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom,
                          $urandom_range(0, 2), 1'($urandom_range(0, 1)), d, e);
        end

        // Zero wait states, both handshakes held high: IDLE, WAIT, RESP repeat every 3 cycles.
        zReqValid = 1'b1; zRspReady = 1'b1; zReqSize = 2'd2; zReqAddr = 32'h0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            checkOutput("zero_ready", 32'(zReqReady), 32'((i % 3) == 2));
            checkOutput("zero_valid", 32'(zRspValid), 32'((i % 3) == 1));
        end
        zReqValid = 1'b0; zRspReady = 1'b0;
        repeat (3) @(posedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
